temp_display_scheduler: RTL and testbench

// Time-shares the 4-digit 7-segment display (HEX_3..HEX_0) between NUM_CH
// 12-bit temperature/average channels. Round-robins the enabled channels,

---
 rtl/temp_display_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_temp_display_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_display_scheduler.sv
// Round-robin 4-digit 7-segment display scheduler with sequential BCD conversion.
// Latency: 14 cycles from SELECT entry to HEX/cur_ch update (1 select + 12 convert + 1 latch).
// Backpressure: none; inputs are sampled only in SELECT, and the display is held for DWELL cycles.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   ch_data_i           : NUM_CH packed 12-bit unsigned channel values, channel i at [12*i +: 12]
//   ch_valid_i          : per-channel display enable
//   hold_i              : re-select the current channel instead of advancing
//   cur_ch_o            : channel currently shown
//   busy_o              : high while converting/latching
//   upd_o               : 1-cycle pulse on the edge where the HEX outputs and cur_ch_o change
//   hex0_o..hex3_o      : active-low segments (bit0=a .. bit6=g), units..thousands
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (units always shown).

module temp_display_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DWELL  = 50_000_000,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [12*NUM_CH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]    ch_valid_i,
  input  logic                 hold_i,
  output logic [CH_W-1:0]      cur_ch_o,
  output logic                 busy_o,
  output logic                 upd_o,
  output logic [6:0]           hex0_o,
  output logic [6:0]           hex1_o,
  output logic [6:0]           hex2_o,
  output logic [6:0]           hex3_o
);

  localparam int         DW_W  = $clog2(DWELL + 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_CONVERT, S_LATCH, S_DWELL} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [11:0]       bin_q;
  logic [15:0]       bcd_q;
  logic [3:0]        cvt_cnt_q;
  logic [DW_W-1:0]   dwell_cnt_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic              busy_q;
  logic              upd_q;
  logic [6:0]        hex0_q, hex1_q, hex2_q, hex3_q;

  logic [11:0]       ch_arr [NUM_CH];
  logic [CH_W-1:0]   cand;
  logic              cand_vld;
  logic [CH_W-1:0]   idx;
  int                sum;
  logic [15:0]       bcd_adj;
  logic [15:0]       bcd_d;
  logic [11:0]       bin_d;
  logic [6:0]        seg0, seg1, seg2, seg3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_arr[g] = ch_data_i[12*g +: 12];
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = BLANK;
    endcase
  endfunction

  // Candidate selection. Scanning from the farthest offset down to the
  // nearest lets the nearest valid channel after ptr win; ptr itself is the
  // last resort (offset NUM_CH).
  always_comb begin
    cand     = ptr_q;
    cand_vld = 1'b0;
    sum      = 0;
    idx      = '0;
    if (hold_i) begin
      cand_vld = ch_valid_i[ptr_q];
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        sum = int'(ptr_q) + k;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        idx = CH_W'(sum);
        if (ch_valid_i[idx]) begin
          cand     = idx;
          cand_vld = 1'b1;
        end
      end
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[14:0], bin_q[11]};
    bin_d = {bin_q[10:0], 1'b0};
  end

  always_comb begin
    seg0 = seg7(bcd_q[3:0]);
    seg1 = seg7(bcd_q[7:4]);
    seg2 = seg7(bcd_q[11:8]);
    seg3 = seg7(bcd_q[15:12]);
`ifdef LEADING_ZERO_BLANK_EN
    if (bcd_q[15:12] == 4'd0) seg3 = BLANK;
    if (bcd_q[15:8]  == 8'd0) seg2 = BLANK;
    if (bcd_q[15:4]  == 12'd0) seg1 = BLANK;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= CH_W'(NUM_CH - 1);
      bin_q       <= '0;
      bcd_q       <= '0;
      cvt_cnt_q   <= '0;
      dwell_cnt_q <= '0;
      cur_ch_q    <= '0;
      busy_q      <= 1'b0;
      upd_q       <= 1'b0;
      hex0_q      <= BLANK;
      hex1_q      <= BLANK;
      hex2_q      <= BLANK;
      hex3_q      <= BLANK;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= S_SELECT;
        S_SELECT: begin
          if (cand_vld) begin
            ptr_q     <= cand;
            bin_q     <= ch_arr[cand];
            bcd_q     <= '0;
            cvt_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_CONVERT;
          end else begin
            // Nothing to show: blank the display but keep cur_ch.
            hex0_q <= BLANK;
            hex1_q <= BLANK;
            hex2_q <= BLANK;
            hex3_q <= BLANK;
          end
        end
        S_CONVERT: begin
          bin_q     <= bin_d;
          bcd_q     <= bcd_d;
          cvt_cnt_q <= cvt_cnt_q + 4'd1;
          if (cvt_cnt_q == 4'd11) state_q <= S_LATCH;
        end
        S_LATCH: begin
          hex0_q      <= seg0;
          hex1_q      <= seg1;
          hex2_q      <= seg2;
          hex3_q      <= seg3;
          cur_ch_q    <= ptr_q;
          upd_q       <= 1'b1;
          busy_q      <= 1'b0;
          dwell_cnt_q <= '0;
          state_q     <= S_DWELL;
        end
        S_DWELL: begin
          if (dwell_cnt_q == DW_W'(DWELL - 1)) begin
            dwell_cnt_q <= '0;
            state_q     <= S_SELECT;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + DW_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cur_ch_o = cur_ch_q;
  assign busy_o   = busy_q;
  assign upd_o    = upd_q;
  assign hex0_o   = hex0_q;
  assign hex1_o   = hex1_q;
  assign hex2_o   = hex2_q;
  assign hex3_o   = hex3_q;

endmodule

// File: tb/tb_temp_display_scheduler.sv
// Directed bench for temp_display_scheduler (NUM_CH=4, DWELL=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_temp_display_scheduler;

  localparam int NUM_CH = 4;
  localparam int DWELL  = 4;

  // Expected {HEX_3,HEX_2,HEX_1,HEX_0}
  localparam logic [27:0] E_BLANK = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] E2047   = {7'h24, 7'h40, 7'h19, 7'h78};
  localparam logic [27:0] E4095   = {7'h19, 7'h40, 7'h10, 7'h12};
  localparam logic [27:0] E1000   = {7'h79, 7'h40, 7'h40, 7'h40};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] E25     = {7'h7F, 7'h7F, 7'h24, 7'h12};
  localparam logic [27:0] E0      = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] E100    = {7'h7F, 7'h79, 7'h40, 7'h40};
  localparam logic [27:0] E999    = {7'h7F, 7'h10, 7'h10, 7'h10};
`else
  localparam logic [27:0] E25     = {7'h40, 7'h40, 7'h24, 7'h12};
  localparam logic [27:0] E0      = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] E100    = {7'h40, 7'h79, 7'h40, 7'h40};
  localparam logic [27:0] E999    = {7'h40, 7'h10, 7'h10, 7'h10};
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ch_data;
  logic [3:0]  ch_valid;
  logic        hold;
  logic [1:0]  cur_ch;
  logic        busy, upd;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [27:0] hex_all;

  int n_cmp = 0;
  int n_err = 0;

  assign hex_all = {hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  temp_display_scheduler #(.NUM_CH(NUM_CH), .DWELL(DWELL)) dut (
    .clk_i(clk), .rst_i(rst), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .hold_i(hold), .cur_ch_o(cur_ch), .busy_o(busy), .upd_o(upd),
    .hex0_o(hex0), .hex1_o(hex1), .hex2_o(hex2), .hex3_o(hex3)
  );

  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_data[12*ch +: 12] = v;
  endtask

  // Called at a negedge; holds reset for two edges and releases at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts posedges until upd is seen (sampled on negedge), bounded by budget.
  task automatic wait_upd(input int budget, output int edges, output int busy_cnt, output bit got);
    edges = 0; busy_cnt = 0; got = 1'b0;
    while (edges < budget && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (upd) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; ch_valid = 4'b0001; ch_data = '0;
    set_ch(0, 12'd2047);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (hex_all !== E_BLANK) begin n_err++; $display("FAIL reset_hex got=%h exp=%h", hex_all, E_BLANK); end
    n_cmp++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL reset_cur_ch got=%0d exp=0", cur_ch); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (upd !== 1'b0) begin n_err++; $display("FAIL reset_upd got=%b exp=0", upd); end
  endtask

  task automatic test_first();
    int e, b; bit got;
    rst = 1'b0;
    wait_upd(40, e, b, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL first_upd_timeout got=none exp=upd"); end
    n_cmp++; if (e !== 15) begin n_err++; $display("FAIL first_latency got=%0d exp=15", e); end
    n_cmp++; if (b !== 13) begin n_err++; $display("FAIL first_busy_cycles got=%0d exp=13", b); end
    n_cmp++; if (hex_all !== E2047) begin n_err++; $display("FAIL first_hex got=%h exp=%h", hex_all, E2047); end
    n_cmp++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL first_cur_ch got=%0d exp=0", cur_ch); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (upd !== 1'b0) begin n_err++; $display("FAIL first_upd_pulse got=%b exp=0", upd); end
  endtask

  task automatic test_rotation();
    int e, b; bit got;
    int          exp_ch  [4] = '{0, 1, 3, 0};
    logic [27:0] exp_hex [4] = '{E25, E4095, E0, E25};
    int          exp_e   [4] = '{15, 18, 18, 18};
    ch_valid = 4'b1011;
    set_ch(0, 12'd25); set_ch(1, 12'd4095); set_ch(2, 12'd777); set_ch(3, 12'd0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_upd(40, e, b, got);
      n_cmp++; if (!got) begin n_err++; $display("FAIL rot%0d_timeout got=none exp=upd", i); end
      n_cmp++; if (e !== exp_e[i]) begin n_err++; $display("FAIL rot%0d_period got=%0d exp=%0d", i, e, exp_e[i]); end
      n_cmp++; if (cur_ch !== exp_ch[i][1:0]) begin n_err++; $display("FAIL rot%0d_cur_ch got=%0d exp=%0d", i, cur_ch, exp_ch[i]); end
      n_cmp++; if (hex_all !== exp_hex[i]) begin n_err++; $display("FAIL rot%0d_hex got=%h exp=%h", i, hex_all, exp_hex[i]); end
    end
  endtask

  task automatic test_hold();
    int e, b; bit got;
    ch_valid = 4'b1011;
    set_ch(0, 12'd25); set_ch(1, 12'd4095); set_ch(3, 12'd0);
    do_reset();
    wait_upd(40, e, b, got);
    wait_upd(40, e, b, got);
    n_cmp++; if (cur_ch !== 2'd1) begin n_err++; $display("FAIL hold_pre_cur_ch got=%0d exp=1", cur_ch); end
    hold = 1'b1;
    set_ch(1, 12'd100);
    wait_upd(40, e, b, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL hold_timeout got=none exp=upd"); end
    n_cmp++; if (e !== 18) begin n_err++; $display("FAIL hold_period got=%0d exp=18", e); end
    n_cmp++; if (cur_ch !== 2'd1) begin n_err++; $display("FAIL hold_cur_ch got=%0d exp=1", cur_ch); end
    n_cmp++; if (hex_all !== E100) begin n_err++; $display("FAIL hold_hex got=%h exp=%h", hex_all, E100); end
    hold = 1'b0;
  endtask

  task automatic test_none_valid();
    int e, b; bit got;
    int n_upd = 0, n_busy = 0;
    ch_valid = 4'b0000;
    do_reset();
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      if (upd) n_upd++;
      if (busy) n_busy++;
    end
    n_cmp++; if (n_upd !== 0) begin n_err++; $display("FAIL none_upd got=%0d exp=0", n_upd); end
    n_cmp++; if (n_busy !== 0) begin n_err++; $display("FAIL none_busy got=%0d exp=0", n_busy); end
    n_cmp++; if (hex_all !== E_BLANK) begin n_err++; $display("FAIL none_hex got=%h exp=%h", hex_all, E_BLANK); end
    set_ch(2, 12'd999);
    ch_valid = 4'b0100;
    wait_upd(40, e, b, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL none_ch2_timeout got=none exp=upd"); end
    n_cmp++; if (e !== 14) begin n_err++; $display("FAIL none_ch2_latency got=%0d exp=14", e); end
    n_cmp++; if (cur_ch !== 2'd2) begin n_err++; $display("FAIL none_ch2_cur_ch got=%0d exp=2", cur_ch); end
    n_cmp++; if (hex_all !== E999) begin n_err++; $display("FAIL none_ch2_hex got=%h exp=%h", hex_all, E999); end
  endtask

  task automatic test_reset_mid_convert();
    int e, b; bit got;
    ch_valid = 4'b1011;
    set_ch(0, 12'd25); set_ch(1, 12'd4095); set_ch(3, 12'd0);
    do_reset();
    wait_upd(40, e, b, got);
    wait_upd(40, e, b, got);
    // 4 dwell + 1 select + 5 convert edges: now inside the 6th convert cycle.
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (hex_all !== E_BLANK) begin n_err++; $display("FAIL mid_rst_hex got=%h exp=%h", hex_all, E_BLANK); end
    n_cmp++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL mid_rst_cur_ch got=%0d exp=0", cur_ch); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    n_cmp++; if (upd !== 1'b0) begin n_err++; $display("FAIL mid_rst_upd got=%b exp=0", upd); end
    rst = 1'b0;
    wait_upd(40, e, b, got);
    n_cmp++; if (e !== 15) begin n_err++; $display("FAIL mid_after_latency got=%0d exp=15", e); end
    n_cmp++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL mid_after_cur_ch got=%0d exp=0", cur_ch); end
    n_cmp++; if (hex_all !== E25) begin n_err++; $display("FAIL mid_after_hex got=%h exp=%h", hex_all, E25); end
  endtask

  task automatic test_values();
    int e, b; bit got;
    logic [11:0] vals [3] = '{12'd0, 12'd1000, 12'd4095};
    logic [27:0] exps [3] = '{E0, E1000, E4095};
    ch_valid = 4'b0001;
    set_ch(0, vals[0]);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_upd(40, e, b, got);
      n_cmp++; if (!got) begin n_err++; $display("FAIL val%0d_timeout got=none exp=upd", i); end
      n_cmp++; if (cur_ch !== 2'd0) begin n_err++; $display("FAIL val%0d_cur_ch got=%0d exp=0", i, cur_ch); end
      n_cmp++; if (hex_all !== exps[i]) begin n_err++; $display("FAIL val%0d_hex got=%h exp=%h", i, hex_all, exps[i]); end
      if (i < 2) set_ch(0, vals[i+1]);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_rotation();
    test_hold();
    test_none_valid();
    test_reset_mid_convert();
    test_values();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
